lzc_normalize_pipe: RTL and testbench
=====================================

Name: lzc_normalize_pipe

Overview:
- Parametrised, pipelined leading-zero / redundant-sign counter with a left-normalising shifter and a valid/ready handshake.
- Successor to the single-register zero counter in fp_common. Used by adders, int-to-float converters and accumulator renormalisation in the FP datapath.
- Adds the following:
  - configurable pipeline depth
  - runtime count mode (leading zeros or redundant sign bits)
  - runtime shift clamp for subnormal handling
  - all-zero and clamp flags
  - sideband tag passthrough
  - backpressure

Parameters:
- WIDTH, 24, data width in bits (>=2).
- DW, $clog2(WIDTH+1), distance width; must hold the value WIDTH.
- LEVELS, $clog2(WIDTH), number of binary shift levels in the tree.
- STAGES, 1, number of register stages, 1..LEVELS; levels are split evenly, and earlier stages take the extra level when the split is uneven.
- TAG_W, 8, sideband tag width, carried unmodified.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input this cycle
- in_data  input  WIDTH  word to normalise
- in_mode  input  1  0 = count leading zeros; 1 = count redundant sign bits
- in_max_shift  input  DW  maximum permitted shift (clamp)
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_result  output  WIDTH  in_data << out_distance, zero-filled from the LSB
- out_distance  output  DW  applied shift = min(count, in_max_shift)
- out_zero  output  1  input had no significant bit (see below)
- out_clamped  output  1  count > in_max_shift, so the shift was limited
- out_tag  output  TAG_W  tag that entered with this word

Behaviour:
- Reset: async assert clears all stage valid bits. out_valid=0 and all out_* data registers = 0 while reset is high and on release; in_ready=1 after release.
- Handshake: en = ~out_valid | out_ready; in_ready = en. All stages advance together when en=1 and hold when en=0.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Bubbles are not collapsed.
- Latency: exactly STAGES enabled cycles from input transfer to out_valid. Full throughput of 1 word/cycle while out_ready=1.
- Count definition, mode 0: count = number of leading 0s, range 0..WIDTH. count = WIDTH iff in_data == 0.
- Count definition, mode 1: count = number of bits below the MSB that equal the MSB, range 0..WIDTH-1.
  - out_zero=1 iff the word is all 0s or all 1s.
  - For all 1s, the result is the all-ones pattern shifted by count, i.e. MSB set, remainder 0.
- Clamp:
  - distance = min(count, in_max_shift).
  - in_max_shift >= WIDTH means no clamp.
  - out_clamped = (count > in_max_shift).
  - in_max_shift = 0 gives passthrough: distance 0, out_clamped=1 iff count>0.
- Shift tree:
  - Level k (k = 1..LEVELS) tests the shift amount 2^(LEVELS-k).
  - Level k shifts only if two conditions hold: the top 2^(LEVELS-k) bits are insignificant for the mode, and (accumulated distance + 2^(LEVELS-k)) <= min(in_max_shift, WIDTH).
  - Mode, clamp and tag travel with the data through every stage register.
  - For non-power-of-two WIDTH, shifts exceeding the remaining width are suppressed, so the distance never exceeds WIDTH.
- Zero case, mode 0, no clamp: distance = WIDTH and result = 0. Level sums can exceed WIDTH, so the final distance saturates at WIDTH.
- All control inputs are sampled only on input transfer; inputs presented while in_ready=0 are ignored.
- Reset asserted mid-stream: all in-flight words are discarded, with no partial output.

Decomposition:
- Package fp_common_pkg provides:
  - typedef enum logic {LZC_ZEROS=1'b0, LZC_SIGN=1'b1} lzc_mode_t
  - function lzc_levels(width) returning the level count
  - function lzc_stage_of_level(level, levels, stages) used by the generate loop
- Sub-module lzc_shift_level is purely combinational: one tree level, parameters WIDTH, DW, SHIFT.
  - Inputs: data, distance, mode, limit.
  - Outputs: data, distance.
- The top level instantiates LEVELS copies and inserts valid/data registers at the stage boundaries.

Test Plan (WIDTH=24, TAG_W=8):
- mode0, data 24'h000100, max 31, tag 8'h5A, STAGES=2 -> after 2 cycles: result 24'h800000, distance 15, zero 0, clamped 0, tag 8'h5A.
- mode0, data 24'h000100, max 8 -> result 24'h010000, distance 8, clamped 1.
- mode0, data 24'h000000, max 31 -> result 24'h000000, distance 24, zero 1, clamped 0. Repeat with mode1 and data 24'hFFFFFF -> result 24'h800000, distance 23, zero 1.
- mode1, data 24'hFFF000 -> result 24'h800000, distance 11. mode1, data 24'h3FFFFF -> result 24'h7FFFFE, distance 1.
- Backpressure, STAGES=3: stream 6 words with tags 0..5 and hold out_ready=0 for 4 cycles mid-stream.
  - in_ready=0 exactly while out_valid & ~out_ready.
  - Tags arrive 0..5 in order, with no loss or duplication.
- Mid-stream reset: assert reset with 2 words in flight -> out_valid=0 immediately (async). After release, no stale word appears; the next input emerges after STAGES cycles.

Source files
------------

// File: rtl/fp_common_pkg.sv
// Shared FP datapath helpers: count-mode encoding and shift-tree stage mapping
// for the leading-zero / redundant-sign normaliser.
package fp_common_pkg;

    typedef enum logic {LZC_ZEROS = 1'b0, LZC_SIGN = 1'b1} lzc_mode_t;

    function automatic int lzc_levels(input int width);
        return $clog2(width);
    endfunction

    // Maps a 1-based tree level to its 0-based register stage; when the split
    // is uneven the earlier stages each carry one extra level.
    function automatic int lzc_stage_of_level(input int level, input int levels, input int stages);
        int base;
        int rem;
        int big;
        base = levels / stages;
        rem  = levels % stages;
        big  = rem * (base + 1);
        if (level - 1 < big)
            return (level - 1) / (base + 1);
        return rem + (level - 1 - big) / base;
    endfunction

endpackage

// File: rtl/lzc_shift_level.sv
// One level of the normalising shift tree: shifts left by SHIFT when the top
// bits carry no information and the accumulated distance stays within limit.
module lzc_shift_level
    import fp_common_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DW    = 5,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic [DW-1:0]    in_distance,
    input  lzc_mode_t        in_mode,
    input  logic [DW-1:0]    in_limit,
    output logic [WIDTH-1:0] out_data,
    output logic [DW-1:0]    out_distance
);

    logic [SHIFT:0] top;
    logic [DW:0]    sum;
    logic           insig;
    logic           take;

    // Sign mode needs the SHIFT bits below the MSB to match the MSB itself.
    assign top   = in_data[WIDTH-1 -: SHIFT+1];
    assign sum   = {1'b0, in_distance} + (DW+1)'(SHIFT);
    assign insig = (in_mode == LZC_SIGN) ? ((top == '0) || (top == '1)) : (top[SHIFT:1] == '0);
    assign take  = insig && (sum <= {1'b0, in_limit});

    assign out_data     = take ? (in_data << SHIFT) : in_data;
    assign out_distance = take ? sum[DW-1:0] : in_distance;

endmodule

// File: rtl/lzc_normalize_pipe.sv
// Pipelined leading-zero / redundant-sign normaliser with shift clamp, zero and
// clamp flags, tag passthrough and a valid/ready handshake.
module lzc_normalize_pipe
    import fp_common_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int DW     = $clog2(WIDTH + 1),
    parameter int LEVELS = lzc_levels(WIDTH),
    parameter int STAGES = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [DW-1:0]    in_max_shift,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [DW-1:0]    out_distance,
    output logic             out_zero,
    output logic             out_clamped,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [DW-1:0]    distance;
        lzc_mode_t        mode;
        logic [DW-1:0]    limit;
        logic             zero;
        logic             clamped;
        logic [TAG_W-1:0] tag;
    } word_t;

    logic              en;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [DW-1:0]     cap;
    word_t             head;
    word_t             node [0:LEVELS];

    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            vld_q <= '0;
        else if (en)
            vld_q <= vld_pipe[STAGES-1:0];
    end

    // Sign mode can never count the MSB itself, so its cap is one lower; this
    // also stops zero-fill from faking an extra redundant bit on all-0 words.
    always_comb begin
        cap           = in_mode ? DW'(WIDTH - 1) : DW'(WIDTH);
        head.data     = in_data;
        head.distance = '0;
        head.mode     = lzc_mode_t'(in_mode);
        head.limit    = (in_max_shift < cap) ? in_max_shift : cap;
        head.zero     = (in_data == '0) || (in_mode && (in_data == '1));
        head.clamped  = 1'b0;
        head.tag      = in_tag;
    end

    assign node[0] = head;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int SHIFT    = 1 << (LEVELS - k);
        localparam bit BOUNDARY = (k == LEVELS) ||
            (lzc_stage_of_level(k, LEVELS, STAGES) != lzc_stage_of_level(k + 1, LEVELS, STAGES));

        logic [WIDTH-1:0] sh_data;
        logic [DW-1:0]    sh_dist;
        word_t            lv;
        word_t            nxt;

        lzc_shift_level #(.WIDTH(WIDTH), .DW(DW), .SHIFT(SHIFT)) u_level (
            .in_data      (node[k-1].data),
            .in_distance  (node[k-1].distance),
            .in_mode      (node[k-1].mode),
            .in_limit     (node[k-1].limit),
            .out_data     (sh_data),
            .out_distance (sh_dist)
        );

        // Clamped when bits were still insignificant but the shift stopped short of the mode cap.
        always_comb begin
            lv          = node[k-1];
            lv.data     = sh_data;
            lv.distance = sh_dist;
            if (k == LEVELS)
                lv.clamped = ((lv.mode == LZC_SIGN) ? (sh_data[WIDTH-1] == sh_data[WIDTH-2]) : ~sh_data[WIDTH-1])
                             && (sh_dist < ((lv.mode == LZC_SIGN) ? DW'(WIDTH - 1) : DW'(WIDTH)));
        end

        if (BOUNDARY) begin : g_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    nxt <= '0;
                else if (en)
                    nxt <= lv;
            end
        end else begin : g_comb
            assign nxt = lv;
        end

        assign node[k] = nxt;
    end

    assign out_result   = node[LEVELS].data;
    assign out_distance = node[LEVELS].distance;
    assign out_zero     = node[LEVELS].zero;
    assign out_clamped  = node[LEVELS].clamped;
    assign out_tag      = node[LEVELS].tag;

endmodule

// File: tb/tb_lzc_normalize_pipe.sv
// Bench for lzc_normalize_pipe: directed vectors, backpressure, random traffic
// against a counting reference model, and mid-stream reset.
module tb_lzc_normalize_pipe;

    localparam int WIDTH  = 24;
    localparam int DW     = 5;
    localparam int STAGES = 3;
    localparam int TAG_W  = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic [DW-1:0]    in_max_shift;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [DW-1:0]    out_distance;
    logic             out_zero;
    logic             out_clamped;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [DW-1:0]    d;
        bit               z;
        bit               c;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t             exp_q [$];
    logic [TAG_W-1:0] rx_tags [$];
    int               errors = 0;
    int               checks = 0;

    lzc_normalize_pipe #(.WIDTH(WIDTH), .DW(DW), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .in_max_shift (in_max_shift),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_distance (out_distance),
        .out_zero     (out_zero),
        .out_clamped  (out_clamped),
        .out_tag      (out_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Count by walking bits from the top, then apply the clamp arithmetically.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input bit m,
                                   input logic [DW-1:0] mx, input logic [TAG_W-1:0] t);
        exp_t e;
        int   cnt;
        cnt = 0;
        if (!m) begin
            while (cnt < WIDTH && d[WIDTH-1-cnt] == 1'b0) cnt++;
        end else begin
            while (cnt < WIDTH-1 && d[WIDTH-2-cnt] == d[WIDTH-1]) cnt++;
        end
        e.z = m ? (cnt == WIDTH-1) : (cnt == WIDTH);
        e.c = cnt > int'(mx);
        e.d = e.c ? mx : DW'(cnt);
        e.r = d << e.d;
        e.t = t;
        return e;
    endfunction

    // Scoreboard: inputs/outputs are stable at the falling edge, and a transfer
    // seen here completes at the following rising edge.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("in_ready_rule", in_ready, (!out_valid) || out_ready);
            if (out_valid && out_ready) begin
                chk("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_result", out_result, e.r);
                    chk("sb_distance", out_distance, e.d);
                    chk("sb_zero", out_zero, e.z);
                    chk("sb_clamped", out_clamped, e.c);
                    chk("sb_tag", out_tag, e.t);
                end
                rx_tags.push_back(out_tag);
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, in_mode, in_max_shift, in_tag));
        end
    end

    // Single word into an idle pipe; expects exactly STAGES cycles of latency.
    task automatic run_vec(input logic [WIDTH-1:0] d, input bit m, input logic [DW-1:0] mx,
                           input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] er,
                           input logic [DW-1:0] ed, input bit ez, input bit ec);
        in_valid = 1'b1; in_data = d; in_mode = m; in_max_shift = mx; in_tag = tg; out_ready = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        @(posedge clock); #1 chk("lat_early", out_valid, 0);
        @(posedge clock); #1 chk("lat_valid", out_valid, 1);
        chk("vec_result", out_result, er);
        chk("vec_distance", out_distance, ed);
        chk("vec_zero", out_zero, ez);
        chk("vec_clamped", out_clamped, ec);
        chk("vec_tag", out_tag, tg);
    endtask

    initial begin
        int  sent;
        bit  acc;
        int  sh;
        logic [WIDTH-1:0] tmp;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        in_max_shift = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_distance", out_distance, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_flags", {out_zero, out_clamped}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);

        run_vec(24'h000100, 1'b0, 5'd31, 8'h5A, 24'h800000, 5'd15, 1'b0, 1'b0);
        run_vec(24'h000100, 1'b0, 5'd8,  8'h11, 24'h010000, 5'd8,  1'b0, 1'b1);
        run_vec(24'h000000, 1'b0, 5'd31, 8'h22, 24'h000000, 5'd24, 1'b1, 1'b0);
        run_vec(24'h000000, 1'b0, 5'd24, 8'h23, 24'h000000, 5'd24, 1'b1, 1'b0);
        run_vec(24'h000000, 1'b0, 5'd10, 8'h24, 24'h000000, 5'd10, 1'b1, 1'b1);
        run_vec(24'hFFFFFF, 1'b1, 5'd31, 8'h33, 24'h800000, 5'd23, 1'b1, 1'b0);
        run_vec(24'h000000, 1'b1, 5'd31, 8'h34, 24'h000000, 5'd23, 1'b1, 1'b0);
        run_vec(24'hFFF000, 1'b1, 5'd31, 8'h44, 24'h800000, 5'd11, 1'b0, 1'b0);
        run_vec(24'hFFF000, 1'b1, 5'd4,  8'h45, 24'hFF0000, 5'd4,  1'b0, 1'b1);
        run_vec(24'h3FFFFF, 1'b1, 5'd31, 8'h55, 24'h7FFFFE, 5'd1,  1'b0, 1'b0);
        run_vec(24'h000100, 1'b0, 5'd0,  8'h66, 24'h000100, 5'd0,  1'b0, 1'b1);
        run_vec(24'h800001, 1'b0, 5'd0,  8'h67, 24'h800001, 5'd0,  1'b0, 1'b0);

        // Backpressure: 6 tagged words with out_ready low for 4 cycles mid-stream.
        @(posedge clock); #1;
        rx_tags.delete();
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready    = !(c >= 4 && c < 8);
            in_valid     = (sent < 6);
            in_data      = 24'h1 << (sent * 3);
            in_mode      = 1'b0;
            in_max_shift = 5'd31;
            in_tag       = TAG_W'(sent);
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_sent", sent, 6);
        chk("bp_count", rx_tags.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rx_tags.size()) chk("bp_order", rx_tags[i], i);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            sh  = $urandom_range(0, WIDTH);
            tmp = 24'($urandom) >> sh;
            in_mode = 1'($urandom_range(0, 1));
            if (in_mode && $urandom_range(0, 1) == 1) tmp = ~tmp;
            in_data      = tmp;
            in_max_shift = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            in_tag       = 8'($urandom);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) @(posedge clock);
        @(posedge clock); #1;
        chk("drain_empty", exp_q.size(), 0);

        // Mid-stream reset with one word stalled at the output and one behind it.
        out_ready = 1'b0; in_mode = 1'b0; in_max_shift = 5'd31;
        in_valid = 1'b1; in_data = 24'h00F000; in_tag = 8'hA1;
        @(posedge clock); #1 in_data = 24'h000F00; in_tag = 8'hA2;
        @(posedge clock); #1 in_valid = 1'b0;
        @(posedge clock); #1;
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        @(negedge clock); #2 reset = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_result", out_result, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            chk("no_stale", out_valid, 0);
        end
        run_vec(24'h000001, 1'b0, 5'd31, 8'hC3, 24'h800000, 5'd23, 1'b0, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
